// File: rtl/uart_tx_wrapper.sv
// rtl/uart_tx_wrapper.sv - UART transmitter: byte FIFO feeding a start/8N/parity/stop serializer
//
// Ports:
//   UART_clk  system/bit clock, one serial bit per cycle
//   rst_n     asynchronous active-low reset
//   wr_en     write strobe, enqueues wr_data when the FIFO is not full
//   wr_data   byte to enqueue
//   full      FIFO holds FIFO_DEPTH entries
//   empty     FIFO holds no entries
//   busy      serializer is mid-frame or in the inter-frame gap
//   overflow  one-cycle pulse after a write that was dropped because the FIFO was full
//   tx        registered serial line, idles high
module uart_tx_wrapper #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit PARITY_ODD = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic       UART_clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [3:0]          GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [7:0]            mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  accept;
  logic                  pop;

  state_t     state, state_nx;
  logic [7:0] shift, shift_nx;
  logic       parity, parity_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [3:0] gap_cnt, gap_cnt_nx;
  logic       tx_nx;
  logic       frame_req;

  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign accept = wr_en && !full;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge UART_clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A write while full is dropped even when a pop frees a slot on the same edge.
      overflow <= wr_en && full;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      parity  <= parity_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      tx      <= tx_nx;
      busy    <= (state_nx != S_IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    parity_nx  = parity;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    tx_nx      = tx;
    pop        = 1'b0;
    frame_req  = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nx     = 1'b1;
        frame_req = 1'b1;
      end
      S_START: begin
        tx_nx      = shift[0];
        bit_cnt_nx = '0;
        state_nx   = S_DATA;
      end
      S_DATA: begin
        if (bit_cnt == 3'd7) begin
          tx_nx    = parity;
          state_nx = S_PARITY;
        end else begin
          // tx presents bit k while bit_cnt==k; shift[1] is the next bit out.
          shift_nx   = {1'b0, shift[7:1]};
          tx_nx      = shift[1];
          bit_cnt_nx = bit_cnt + 3'd1;
        end
      end
      S_PARITY: begin
        tx_nx    = 1'b1;
        state_nx = S_STOP;
      end
      S_STOP: begin
        if (GAP_CYCLES == 0) begin
          frame_req = 1'b1;
        end else begin
          tx_nx      = 1'b1;
          gap_cnt_nx = '0;
          state_nx   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          frame_req = 1'b1;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end
      default: begin
        tx_nx    = 1'b1;
        state_nx = S_IDLE;
      end
    endcase

    // Shared frame launch from IDLE, STOP and end of GAP: a queued byte starts
    // the next frame with no idle bit, otherwise the line returns to idle.
    if (frame_req) begin
      if (!empty) begin
        pop       = 1'b1;
        shift_nx  = mem[rd_ptr];
        parity_nx = PARITY_ODD ? ~^mem[rd_ptr] : ^mem[rd_ptr];
        tx_nx     = 1'b0;
        state_nx  = S_START;
      end else begin
        tx_nx    = 1'b1;
        state_nx = S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// tb/tb_uart_tx_wrapper.sv - self-checking bench for uart_tx_wrapper (odd/no-gap and even/gap-2 builds)
module tb_uart_tx_wrapper;

  localparam int GAP1 = 2;

  typedef struct packed {
    logic [7:0]  data;
    logic        par;
    logic        stp;
    logic [31:0] start;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       wr_en = '0;
  logic [1:0][7:0]  wr_data = '0;
  logic [1:0]       full, empty, busy, overflow, tx;
  logic [31:0]      cyc = '0;
  int               passed = 0;
  int               total = 0;

  // Reference model state: per-instance FIFO occupancy, accepted bytes and decoded frames.
  frame_t      got_q [2][$];
  logic [7:0]  exp_q [2][$];
  int          mcount [2];
  int          mon_idx [2] = '{-1, -1};
  logic [10:0] mon_bits [2];
  logic [31:0] mon_start [2];
  logic [1:0]  exp_ovf = '0;
  logic [1:0]  exp_full = '0;
  logic [1:0]  exp_empty = 2'b11;
  logic        m_pop, m_acc;
  frame_t      m_frame;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_wrapper u_odd (
    .UART_clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .full(full[0]), .empty(empty[0]), .busy(busy[0]), .overflow(overflow[0]), .tx(tx[0])
  );

  uart_tx_wrapper #(.PARITY_ODD(1'b0), .GAP_CYCLES(GAP1)) u_even (
    .UART_clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .full(full[1]), .empty(empty[1]), .busy(busy[1]), .overflow(overflow[1]), .tx(tx[1])
  );

  function automatic logic par_of(input int i, input logic [7:0] d);
    return (i == 0) ? ~^d : ^d;
  endfunction

  // Runs just after every rising edge: a byte leaves the FIFO exactly when a
  // new start bit appears on an idle line; frames are decoded bit by bit.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mcount[i]  = 0;
        mon_idx[i] = -1;
        exp_q[i].delete();
        exp_ovf[i]   = 1'b0;
        exp_full[i]  = 1'b0;
        exp_empty[i] = 1'b1;
      end else begin
        m_pop = (mon_idx[i] < 0) && (tx[i] == 1'b0);
        m_acc = wr_en[i] && (mcount[i] < 16);
        exp_ovf[i] = wr_en[i] && (mcount[i] == 16);
        if (m_acc) exp_q[i].push_back(wr_data[i]);
        mcount[i] = mcount[i] + int'(m_acc) - int'(m_pop);
        exp_full[i]  = (mcount[i] == 16);
        exp_empty[i] = (mcount[i] == 0);
        if (m_pop) begin
          mon_idx[i]   = 0;
          mon_bits[i]  = '0;
          mon_start[i] = cyc;
        end else if (mon_idx[i] >= 0) begin
          mon_idx[i] = mon_idx[i] + 1;
          mon_bits[i][mon_idx[i]] = tx[i];
          if (mon_idx[i] == 10) begin
            m_frame.data  = mon_bits[i][8:1];
            m_frame.par   = mon_bits[i][9];
            m_frame.stp   = mon_bits[i][10];
            m_frame.start = mon_start[i];
            got_q[i].push_back(m_frame);
            mon_idx[i] = -1;
          end
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(empty == 2'b11 && busy == 2'b00) && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 600) $display("FAIL %s_drain: busy=%b empty=%b, required busy=00 empty=11", tag, busy, empty);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if ({tx[i], busy[i], empty[i], full[i], overflow[i]} !== 5'b10100)
          $display("FAIL reset_idle inst%0d c%0d: tx,busy,empty,full,ovf=%b, required 10100",
                   i, c, {tx[i], busy[i], empty[i], full[i], overflow[i]});
        else passed++;
      end
    end
  endtask

  task automatic test_single();
    logic [10:0] seq = 11'b11101001010;  // 0,1,0,1,0,0,1,0,1,1,1 read from bit 0
    @(negedge clk);
    wr_en[0] = 1'b1;
    wr_data[0] = 8'hA5;
    @(negedge clk);
    wr_en[0] = 1'b0;
    total++;
    if (tx[0] !== 1'b1) $display("FAIL single_no_bypass: tx=%b, required 1", tx[0]);
    else passed++;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      total++;
      if ({tx[0], busy[0]} !== {seq[k], 1'b1})
        $display("FAIL single_bit%0d: tx,busy=%b, required %b", k, {tx[0], busy[0]}, {seq[k], 1'b1});
      else passed++;
    end
    @(negedge clk);
    total++;
    if ({tx[0], busy[0]} !== 2'b10) $display("FAIL single_after: tx,busy=%b, required 10", {tx[0], busy[0]});
    else passed++;
    wait_drain("single");
    total++;
    if (got_q[0].size() != 1) $display("FAIL single_rx_count: got %0d frames, required 1", got_q[0].size());
    else if ({got_q[0][0].data, got_q[0][0].par, got_q[0][0].stp} !== {8'hA5, 1'b1, 1'b1})
      $display("FAIL single_rx: data=%h par=%b stop=%b, required a5 1 1",
               got_q[0][0].data, got_q[0][0].par, got_q[0][0].stp);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      got_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h5A, 8'h3C, 8'h00};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_en = 2'b11;
      wr_data[0] = bytes[k];
      wr_data[1] = bytes[k];
    end
    @(negedge clk);
    wr_en = '0;
    wait_drain("b2b");
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_q[i].size() != 3) $display("FAIL b2b_count inst%0d: got %0d frames, required 3", i, got_q[i].size());
      else passed++;
      for (int k = 0; k < 3 && k < got_q[i].size(); k++) begin
        total++;
        if ({got_q[i][k].data, got_q[i][k].par, got_q[i][k].stp} !== {bytes[k], par_of(i, bytes[k]), 1'b1})
          $display("FAIL b2b_frame inst%0d #%0d: data=%h par=%b stop=%b, required %h %b 1", i, k,
                   got_q[i][k].data, got_q[i][k].par, got_q[i][k].stp, bytes[k], par_of(i, bytes[k]));
        else passed++;
        if (k > 0) begin
          total++;
          if (got_q[i][k].start - got_q[i][k-1].start !== 32'(11 + (i == 1 ? GAP1 : 0)))
            $display("FAIL b2b_period inst%0d #%0d: period=%0d, required %0d", i, k,
                     got_q[i][k].start - got_q[i][k-1].start, 11 + (i == 1 ? GAP1 : 0));
          else passed++;
        end
      end
      got_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic test_even_parity();
    @(negedge clk);
    wr_en[1] = 1'b1;
    wr_data[1] = 8'h3C;
    @(negedge clk);
    wr_en[1] = 1'b0;
    wait_drain("even");
    total++;
    if (got_q[1].size() != 1 || got_q[1][0].data !== 8'h3C || got_q[1][0].par !== 1'b0)
      $display("FAIL even_parity: frames=%0d data=%h par=%b, required 1 3c 0",
               got_q[1].size(), got_q[1].size() > 0 ? got_q[1][0].data : 8'h00,
               got_q[1].size() > 0 ? got_q[1][0].par : 1'bx);
    else passed++;
    total++;
    if (got_q[1].size() == 1 && (got_q[1][0].par === ~^got_q[1][0].data))
      $display("FAIL even_into_odd_pe: pe=0, required 1");
    else passed++;
    got_q[1].delete();
    exp_q[1].delete();
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          total++;
          if ({overflow[i], full[i], empty[i]} !== {exp_ovf[i], exp_full[i], exp_empty[i]})
            $display("FAIL rand_flags inst%0d: ovf,full,empty=%b, required %b", i,
                     {overflow[i], full[i], empty[i]}, {exp_ovf[i], exp_full[i], exp_empty[i]});
          else passed++;
          wr_en[i] = ($urandom_range(0, 3) != 0);
          wr_data[i] = 8'($urandom);
        end
      end
      @(negedge clk);
      wr_en = '0;
      wait_drain("rand");
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[i].size() != exp_q[i].size())
          $display("FAIL rand_count inst%0d: got %0d frames, required %0d", i, got_q[i].size(), exp_q[i].size());
        else passed++;
        for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
          total++;
          if ({got_q[i][k].data, got_q[i][k].par, got_q[i][k].stp} !== {exp_q[i][k], par_of(i, exp_q[i][k]), 1'b1})
            $display("FAIL rand_frame inst%0d #%0d: data=%h par=%b stop=%b, required %h %b 1", i, k,
                     got_q[i][k].data, got_q[i][k].par, got_q[i][k].stp, exp_q[i][k], par_of(i, exp_q[i][k]));
          else passed++;
        end
        got_q[i].delete();
        exp_q[i].delete();
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_seen = 0;
    @(negedge clk);
    wr_en[0] = 1'b1;
    wr_data[0] = 8'h81;
    @(negedge clk);
    wr_en[0] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      total++;
      if ({overflow[0], full[0], empty[0]} !== {exp_ovf[0], exp_full[0], exp_empty[0]})
        $display("FAIL ovf_flags c%0d: ovf,full,empty=%b, required %b", c,
                 {overflow[0], full[0], empty[0]}, {exp_ovf[0], exp_full[0], exp_empty[0]});
      else passed++;
      if (overflow[0]) ovf_seen++;
      wr_en[0] = (c < 20);
      wr_data[0] = 8'($urandom);
    end
    wr_en[0] = 1'b0;
    total++;
    if (ovf_seen == 0) $display("FAIL ovf_pulse: saw 0 overflow pulses, required at least 1");
    else passed++;
    wait_drain("ovf");
    total++;
    if (got_q[0].size() != exp_q[0].size())
      $display("FAIL ovf_count: got %0d frames, required %0d", got_q[0].size(), exp_q[0].size());
    else passed++;
    for (int k = 0; k < got_q[0].size() && k < exp_q[0].size(); k++) begin
      total++;
      if ({got_q[0][k].data, got_q[0][k].par} !== {exp_q[0][k], par_of(0, exp_q[0][k])})
        $display("FAIL ovf_frame #%0d: data=%h par=%b, required %h %b", k,
                 got_q[0][k].data, got_q[0][k].par, exp_q[0][k], par_of(0, exp_q[0][k]));
      else passed++;
    end
    got_q[0].delete();
    exp_q[0].delete();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_en[0] = 1'b1;
    wr_data[0] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_data[0] = 8'($urandom);
    end
    @(negedge clk);
    wr_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy[0], empty[0]} !== 2'b10) $display("FAIL mid_pre: busy,empty=%b, required 10", {busy[0], empty[0]});
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx[0], busy[0], empty[0]} !== 3'b101)
      $display("FAIL mid_async: tx,busy,empty=%b, required 101", {tx[0], busy[0], empty[0]});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if ({tx[0], busy[0], empty[0]} !== 3'b101)
        $display("FAIL mid_after c%0d: tx,busy,empty=%b, required 101", c, {tx[0], busy[0], empty[0]});
      else passed++;
    end
    total++;
    if (got_q[0].size() != 0) $display("FAIL mid_frames: got %0d frames, required 0", got_q[0].size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_even_parity();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
